// File: rtl/bin2bcd_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_ctrl_pkg : shared state encoding and digit-correction helper.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bin2bcd_seq_ctrl_pkg;

  // 2'd3 is never entered; the controller decodes it as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] DABBLE_THRESH = 4'd5;
  localparam logic [3:0] DABBLE_ADJ    = 4'd3;

  function automatic logic [3:0] dabble(input logic [3:0] digit);
    return (digit >= DABBLE_THRESH) ? digit + DABBLE_ADJ : digit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq_ctrl_dabble_digit.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_ctrl_dabble_digit : one BCD digit correction (+3 when >= 5).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bin2bcd_seq_ctrl_dabble_digit
  import bin2bcd_seq_ctrl_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // The 4-bit add wraps; a carry out can never occur for valid BCD inputs.
  assign dout = dabble(din);

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq_ctrl.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_ctrl : sequential shift-and-add-3 binary-to-BCD converter with
// start/done handshake and overflow detection. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bin2bcd_seq_ctrl
  import bin2bcd_seq_ctrl_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int SCR_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   shift_reg;
  logic [SCR_W-1:0]   scratch;
  logic               ovf;
  logic [CNT_W-1:0]   cnt;

  logic [SCR_W-1:0]   corrected;
  logic [SCR_W-1:0]   next_scratch;
  logic [WIDTH-1:0]   next_shift;
  logic               shift_out;
  logic               next_ovf;
  logic               last_shift;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bin2bcd_seq_ctrl_dabble_digit u_dabble (
      .din  (scratch[4*i +: 4]),
      .dout (corrected[4*i +: 4])
    );
  end

  // Correction first, then one left shift of {scratch, shift_reg}.
  assign next_scratch = {corrected[SCR_W-2:0], shift_reg[WIDTH-1]};
  assign next_shift   = shift_reg << 1;
  assign shift_out    = corrected[SCR_W-1];
  assign next_ovf     = ovf | shift_out;
  assign last_shift   = (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ST_SHIFT: begin
          shift_reg <= next_shift;
          scratch   <= next_scratch;
          ovf       <= next_ovf;
          cnt       <= cnt + 1'b1;
          if (last_shift) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            bcd      <= next_scratch;
            overflow <= next_ovf;
          end
        end
        // IDLE, DONE and the unused encoding all behave as "ready".
        default: begin
          done <= 1'b0;
          if (start) begin
            state     <= ST_SHIFT;
            busy      <= 1'b1;
            shift_reg <= bin;
            scratch   <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire
